// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: SPI memory sequencer (address/RW decode, burst data)
// Ports: clk, reset_n, cs, SCLK edge pulses, mosi -> registered strobes
module spi_burst_ctrl #(
   parameter int ADDR_BITS = 7,
   parameter int DATA_BITS = 8,
   parameter bit BURST_EN  = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic cs,
   input  logic positiveedge_sclk,
   input  logic negativeedge_sclk,
   input  logic mosi,
   output logic miso_buf,
   output logic addr_we,
   output logic sr_we,
   output logic dm_we,
   output logic addr_inc,
   output logic busy
);

   localparam int CNT_MAX =
      (ADDR_BITS + 1 > DATA_BITS) ? ADDR_BITS + 1 : DATA_BITS;
   localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BITS);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);

   typedef enum logic [3:0] {
      IDLE,
      GET_ADDR,
      LATCH,
      READ_LOAD,
      READ_SHIFT,
      READ_NEXT,
      WRITE_SHIFT,
      WRITE_MEM,
      WRITE_NEXT,
      DONE
   } state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          rw, rw_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         rw       <= 1'b0;
         miso_buf <= 1'b0;
         addr_we  <= 1'b0;
         sr_we    <= 1'b0;
         dm_we    <= 1'b0;
         addr_inc <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         rw       <= rw_d;
         // outputs are decoded from the next state so they
         // line up with the state they belong to
         miso_buf <= (state_d == READ_LOAD) ||
                     (state_d == READ_SHIFT) ||
                     (state_d == READ_NEXT);
         addr_we  <= (state_d == LATCH);
         sr_we    <= (state_d == READ_LOAD);
         dm_we    <= (state_d == WRITE_MEM);
         addr_inc <= (state_d == READ_NEXT) ||
                     (state_d == WRITE_NEXT);
         busy     <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      rw_d    = rw;
      if (cs) begin
         state_d = IDLE;
      end else begin
         unique case (state)
            IDLE: state_d = GET_ADDR;
            GET_ADDR: begin
               if (positiveedge_sclk) begin
                  if (cnt == ADDR_LAST) begin
                     rw_d    = mosi;
                     state_d = LATCH;
                  end else begin
                     cnt_d = cnt + 1'b1;
                  end
               end
            end
            LATCH: state_d = rw ? READ_LOAD : WRITE_SHIFT;
            READ_LOAD: state_d = READ_SHIFT;
            READ_SHIFT: begin
               if (negativeedge_sclk) begin
                  if (cnt == DATA_LAST)
                     state_d = BURST_EN ? READ_NEXT : DONE;
                  else
                     cnt_d = cnt + 1'b1;
               end
            end
            READ_NEXT: state_d = READ_LOAD;
            WRITE_SHIFT: begin
               if (positiveedge_sclk) begin
                  if (cnt == DATA_LAST)
                     state_d = WRITE_MEM;
                  else
                     cnt_d = cnt + 1'b1;
               end
            end
            WRITE_MEM: state_d = BURST_EN ? WRITE_NEXT : DONE;
            WRITE_NEXT: state_d = WRITE_SHIFT;
            DONE: state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
      // every state entry starts a fresh bit count
      if (state_d != state)
         cnt_d = '0;
   end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb_spi_burst_ctrl: random SPI transactions vs event-level model
// Drives a burst and a single-byte instance with the same stimulus
module tb_spi_burst_ctrl;

   localparam int MAXL = 256;

   logic clk = 1'b0;
   logic reset_n, cs, pe, ne, mosi;
   logic b_miso, b_awe, b_srwe, b_dmwe, b_inc, b_busy;
   logic s_miso, s_awe, s_srwe, s_dmwe, s_inc, s_busy;
   logic [5:0] ob, os;

   int n_chk = 0;
   int n_pass = 0;

   bit   cs_a[MAXL], pp_a[MAXL], np_a[MAXL], mo_a[MAXL];
   logic [5:0] ex[2][MAXL];
   int   dt[24];
   int   a7, n_cs, j_cs, len;

   always #5 clk = ~clk;

   spi_burst_ctrl #(.BURST_EN(1'b1)) u_burst (
      .clk(clk), .reset_n(reset_n), .cs(cs),
      .positiveedge_sclk(pe), .negativeedge_sclk(ne),
      .mosi(mosi), .miso_buf(b_miso), .addr_we(b_awe),
      .sr_we(b_srwe), .dm_we(b_dmwe), .addr_inc(b_inc),
      .busy(b_busy)
   );

   spi_burst_ctrl #(.BURST_EN(1'b0)) u_single (
      .clk(clk), .reset_n(reset_n), .cs(cs),
      .positiveedge_sclk(pe), .negativeedge_sclk(ne),
      .mosi(mosi), .miso_buf(s_miso), .addr_we(s_awe),
      .sr_we(s_srwe), .dm_we(s_dmwe), .addr_inc(s_inc),
      .busy(s_busy)
   );

   // bit order: busy, miso_buf, addr_we, sr_we, dm_we, addr_inc
   assign ob = {b_busy, b_miso, b_awe, b_srwe, b_dmwe, b_inc};
   assign os = {s_busy, s_miso, s_awe, s_srwe, s_dmwe, s_inc};

   task automatic chk(input string tag, input logic [5:0] obs,
                      input logic [5:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
   endtask

   task automatic drive(input bit c, input bit p, input bit n,
                        input bit m);
      cs = c; pe = p; ne = n; mosi = m;
      @(posedge clk);
      #1;
   endtask

   // counted pulse plus an optional pulse of the other polarity
   task automatic put_pulse(input int t, input bit is_pos);
      int r;
      r = int'($urandom_range(0, 2));
      if (is_pos) pp_a[t] = 1'b1; else np_a[t] = 1'b1;
      if (r == 0) begin
         if (is_pos) np_a[t] = 1'b1; else pp_a[t] = 1'b1;
      end else if (r == 1) begin
         if (is_pos) np_a[t+2] = 1'b1; else pp_a[t+2] = 1'b1;
      end
   endtask

   // mode 0: full, 1: abort after data pulse ab,
   // 2: cs rises on last completing pulse, 3: abort in address
   task automatic gen(input bit rw, input int nb, input int mode,
                      input int ab);
      int t, p;
      for (int i = 0; i < MAXL; i++) begin
         cs_a[i] = 1'b1; pp_a[i] = 1'b0; np_a[i] = 1'b0;
         mo_a[i] = 1'($urandom);
      end
      n_cs = 2 + int'($urandom_range(0, 2));
      t = n_cs;
      for (int i = 0; i <= 7; i++) begin
         t += int'($urandom_range(4, 6));
         put_pulse(t, 1'b1);
      end
      a7 = t;
      mo_a[a7] = rw;
      for (int i = 0; i < 8 * nb; i++) begin
         t += int'($urandom_range(4, 6));
         dt[i] = t;
         put_pulse(t, !rw);
      end
      case (mode)
         1: begin
            p = (ab >= 0) ? ab : int'($urandom_range(0, 8 * nb - 2));
            j_cs = dt[p] + int'($urandom_range(1, 3));
         end
         2: j_cs = dt[8 * nb - 1];
         3: j_cs = a7 - int'($urandom_range(0, 8));
         default: j_cs = t + int'($urandom_range(3, 5));
      endcase
      len = j_cs + 3;
      for (int i = n_cs; i < j_cs; i++) cs_a[i] = 1'b0;
   endtask

   // expected strobes from byte-completion times and cs window
   task automatic model(input int b, input bit rw, input int nb);
      int k_t, mend;
      for (int i = 0; i < MAXL; i++) ex[b][i] = '0;
      for (int i = n_cs; i < j_cs; i++) ex[b][i][5] = 1'b1;
      if (a7 < j_cs) begin
         ex[b][a7][3] = 1'b1;
         if (!rw) begin
            for (int k = 0; k < nb; k++) begin
               k_t = dt[8 * k + 7];
               if (k_t >= j_cs) break;
               ex[b][k_t][1] = 1'b1;
               if (b == 0) break;
               if (k_t + 1 < j_cs) ex[b][k_t + 1][0] = 1'b1;
            end
         end else begin
            mend = j_cs;
            if (a7 + 1 < j_cs) ex[b][a7 + 1][2] = 1'b1;
            for (int k = 0; k < nb; k++) begin
               k_t = dt[8 * k + 7];
               if (k_t >= j_cs) break;
               if (b == 0) begin
                  mend = k_t;
                  break;
               end
               ex[b][k_t][0] = 1'b1;
               if (k_t + 1 < j_cs) ex[b][k_t + 1][2] = 1'b1;
            end
            for (int i = a7 + 1; i < mend; i++) ex[b][i][4] = 1'b1;
         end
      end
   endtask

   task automatic run_txn(input bit rw, input int nb, input int mode,
                          input int ab, input int id);
      gen(rw, nb, mode, ab);
      model(1, rw, nb);
      model(0, rw, nb);
      for (int t = 0; t < len; t++) begin
         drive(cs_a[t], pp_a[t], np_a[t], mo_a[t]);
         chk($sformatf("txn%0d burst c%0d", id, t), ob, ex[1][t]);
         chk($sformatf("txn%0d single c%0d", id, t), os, ex[0][t]);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      cs = 1'b0; pe = 1'b0; ne = 1'b0; mosi = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, i[0], !i[0], 1'b1);
         chk("rst_hold_b", ob, 6'b0);
         chk("rst_hold_s", os, 6'b0);
      end
      reset_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_rel_b", ob, 6'b100000);
      chk("rst_rel_s", os, 6'b100000);
      for (int i = 0; i < 12; i++)
         drive(1'b0, (i % 4) == 1, (i % 4) == 3, 1'b1);
      chk("addr_busy", ob, 6'b100000);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_b", ob, 6'b0);
      chk("rst_async_s", os, 6'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_hold", ob, 6'b0);
      reset_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("idle_b", ob, 6'b0);
      chk("idle_s", os, 6'b0);

      run_txn(1'b0, 1, 0, -1, 0);
      run_txn(1'b0, 3, 0, -1, 1);
      run_txn(1'b1, 2, 0, -1, 2);
      run_txn(1'b0, 2, 1, 4, 3);
      run_txn(1'b0, 1, 0, -1, 4);
      run_txn(1'b0, 1, 2, -1, 5);
      run_txn(1'b1, 1, 2, -1, 6);
      run_txn(1'b1, 2, 3, -1, 7);
      for (int i = 8; i < 48; i++)
         run_txn(1'($urandom), int'($urandom_range(1, 3)),
                 int'($urandom_range(0, 3)), -1, i);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_burst_ctrl.md
# spi_burst_ctrl

Sequencing controller for the SPI memory datapath. It sits between the input conditioners (which supply `cs`, `mosi` and one-cycle SCLK edge pulses) and the address latch, shift register, data memory and MISO buffer. It decodes the 7-bit address and R/W bit, then drives the write enables for each of those blocks. It adds burst mode: while `cs` stays low, consecutive data bytes go to consecutive addresses.

## Interface
Parameters:
- `ADDR_BITS`, 7: address bits received before the R/W bit.
- `DATA_BITS`, 8: bits per data byte.
- `BURST_EN`, 1: 1 allows multi-byte transactions; 0 limits each transaction to a single byte.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cs`  in  1  conditioned chip select, active low.
- `positiveedge_sclk`  in  1  one-`clk` pulse on each SCLK rising edge.
- `negativeedge_sclk`  in  1  one-`clk` pulse on each SCLK falling edge.
- `mosi`  in  1  conditioned serial data in.
- `miso_buf`  out  1  MISO tri-state enable.
- `addr_we`  out  1  address latch load strobe.
- `sr_we`  out  1  shift register parallel-load strobe (data from memory).
- `dm_we`  out  1  data memory write strobe.
- `addr_inc`  out  1  address latch post-increment strobe.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- All outputs are registered. The reset value of every output is 0, and the state resets to IDLE.
- Internal registers:
  - bit counter, width clog2(max(ADDR_BITS+1, DATA_BITS)), cleared on every state entry;
  - `rw` flag, captured from `mosi` on the (ADDR_BITS+1)th positive-edge pulse.
- States:
  - IDLE: all outputs 0. `cs`=0 moves to GET_ADDR.
  - GET_ADDR: count `positiveedge_sclk` pulses. The (ADDR_BITS+1)th pulse captures `rw` and moves to LATCH.
  - LATCH: `addr_we`=1 for one cycle. Next state is READ_LOAD if `rw`=1, otherwise WRITE_SHIFT.
  - READ_LOAD: `sr_we`=1 and `miso_buf`=1 for one cycle, then READ_SHIFT.
  - READ_SHIFT: `miso_buf`=1. Count `negativeedge_sclk` pulses. On the DATA_BITS-th pulse, go to READ_NEXT if `BURST_EN`, else DONE.
  - READ_NEXT: `addr_inc`=1 and `miso_buf`=1 for one cycle, then READ_LOAD.
  - WRITE_SHIFT: count `positiveedge_sclk` pulses. On the DATA_BITS-th pulse, go to WRITE_MEM.
  - WRITE_MEM: `dm_we`=1 for one cycle. Next state is WRITE_NEXT if `BURST_EN`, else DONE.
  - WRITE_NEXT: `addr_inc`=1 for one cycle, then WRITE_SHIFT.
  - DONE: all strobes 0 and `miso_buf`=0; edge pulses are ignored. Remain here until `cs`=1.
- `cs`=1 in any state forces IDLE on the next edge and has priority over every other transition.
  - A partial byte is discarded; no `dm_we` or `addr_inc` is issued.
  - If `cs` rises in the same cycle as the completing edge pulse, no strobe is issued.
- If `positiveedge_sclk` and `negativeedge_sclk` are both high in one cycle, each state counts only the pulse it uses; the other is ignored.
- Edge pulses arriving during one-cycle strobe states (LATCH, READ_LOAD, READ_NEXT, WRITE_MEM, WRITE_NEXT) are not counted. The SCLK period must be at least 4 `clk` cycles.
- Address wrap-around on `addr_inc` is handled by the address latch; this block only issues the strobe.
- Asserting `reset_n`=0 mid-transaction clears all state and outputs immediately. After release, the block waits in IDLE and re-arms only on `cs`=0; if `cs` is already low, it enters GET_ADDR on the first clock after release.

## Timing
- `cs` falls at sample edge N: GET_ADDR and `busy`=1 after edge N.
- Last address/R/W pulse sampled at edge M: `addr_we`=1 for the cycle after edge M (exactly 1 cycle).
- Read: `sr_we` one cycle after `addr_we`. `miso_buf` rises together with `sr_we` and stays high until DONE or IDLE.
- Write: last data pulse at edge K gives `dm_we` high for the cycle after K. `addr_inc` (burst) follows in the next cycle.
- Read burst: DATA_BITS-th negative pulse at edge K gives `addr_inc` in the cycle after K, then `sr_we` in the following cycle.
- `cs` rising at edge J: all outputs 0 and `busy`=0 after edge J.

## Test plan
- Reset: `reset_n`=0 for 2 cycles with `cs`=0 and pulses toggling → all outputs 0. After release, `busy`=1 one cycle later.
- Write, single byte, `BURST_EN`=0: address 0x15 then R/W=0, then 8 data pulses → `addr_we` exactly 1 cycle after the 8th pulse, `dm_we` exactly 1 cycle after the 16th pulse, `addr_inc` never asserted, `busy` stays 1 until `cs`=1.
- Write burst, 3 bytes: → 3 `dm_we` pulses, each followed next cycle by `addr_inc`; `miso_buf` stays 0 throughout.
- Read burst, 2 bytes: address 0x7F then R/W=1 → `addr_we`, then `sr_we` 1 cycle later with `miso_buf`=1. After 8 negative pulses, `addr_inc` then `sr_we`; `miso_buf` held 1 until `cs` rises.
- Abort: `cs`=1 after 5 data pulses of a write → `dm_we` never asserted, all outputs 0 the next cycle. A following transaction works normally.
- Simultaneous events: both edge pulses high together during WRITE_SHIFT → counter advances by exactly 1. `cs` rising on the 8th data pulse → no `dm_we`.
